// File: rtl/alsu_cmp_scheduler_pkg.sv
// Shared opcode and FSM state definitions for the ALSU compare/bypass scheduler.
package alsu_cmp_scheduler_pkg;

  localparam logic [1:0] OP_PASS_A = 2'b00;
  localparam logic [1:0] OP_PASS_B = 2'b01;
  localparam logic [1:0] OP_EQ     = 2'b10;
  localparam logic [1:0] OP_SLT    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/alsu_cmp_scheduler_rr_arb2.sv
// Two-input round-robin arbiter: the pointed-to requester wins, otherwise the other one.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req[ptr]) begin
      gnt[ptr] = 1'b1;
    end else if (req[~ptr]) begin
      gnt[~ptr] = 1'b1;
    end
  end

endmodule

// File: rtl/alsu_cmp_scheduler.sv
// Shares one bypass/equality/SLT datapath between two requesters with round-robin grant.
//   state   | meaning
//   ST_IDLE | waiting for a request; req_ready offered combinationally
//   ST_EXEC | compute on latched operands, register result
//   ST_RESP | hold rsp_valid/rsp_data/rsp_id until rsp_ready
module alsu_cmp_scheduler
  import alsu_cmp_scheduler_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1,
  output logic             busy
);

  state_t           state_q, state_d;
  logic             rr_ptr;
  logic [1:0]       gnt;
  logic             load;
  logic [WIDTH-1:0] a_q, b_q;
  logic [1:0]       op_q;
  logic             id_q;
  logic [WIDTH-1:0] result;

  rr_arb2 u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    req_ready = 2'b00;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy      = 1'b0;
        req_ready = gnt;
        if (gnt != 2'b00) begin
          load    = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    result = '0;
    case (op_q)
      OP_PASS_A: result    = a_q;
      OP_PASS_B: result    = b_q;
      OP_EQ:     result[0] = (a_q == b_q);
      default:   result[0] = (a_q < b_q);
    endcase
  end

  // Operands are captured only on grant so later requester changes cannot leak in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      id_q     <= 1'b0;
      rsp_data <= '0;
      rsp_id   <= 1'b0;
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (load) begin
        a_q    <= gnt[1] ? req1_a  : req0_a;
        b_q    <= gnt[1] ? req1_b  : req0_b;
        op_q   <= gnt[1] ? req1_op : req0_op;
        id_q   <= gnt[1];
        rr_ptr <= ~gnt[1];
        if (gnt[0] && (gnt_cnt0 != {CNT_W{1'b1}})) gnt_cnt0 <= gnt_cnt0 + 1'b1;
        if (gnt[1] && (gnt_cnt1 != {CNT_W{1'b1}})) gnt_cnt1 <= gnt_cnt1 + 1'b1;
      end
      if (state_q == ST_EXEC) begin
        rsp_data <= result;
        rsp_id   <= id_q;
      end
    end
  end

endmodule

// File: tb/tb_alsu_cmp_scheduler.sv
// Scoreboard bench for alsu_cmp_scheduler: cycle model predicts grants, results queued at grant.
module tb_alsu_cmp_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] req_valid = 2'b00;
  logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [1:0] req0_op = '0, req1_op = '0;
  logic       rsp_ready = 1'b1;

  logic [1:0] req_ready, s_req_ready;
  logic       rsp_valid, rsp_id, busy, s_rsp_valid, s_rsp_id, s_busy;
  logic [3:0] rsp_data, s_rsp_data;
  logic [7:0] gnt_cnt0, gnt_cnt1;
  logic [1:0] s_gnt_cnt0, s_gnt_cnt1;

  int vectors = 0;
  int miscompares = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  alsu_cmp_scheduler #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .busy(busy)
  );

  alsu_cmp_scheduler #(.WIDTH(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(s_req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(s_rsp_data), .rsp_id(s_rsp_id),
    .gnt_cnt0(s_gnt_cnt0), .gnt_cnt1(s_gnt_cnt1), .busy(s_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_res(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] op);
    case (op)
      2'b00:   return a;
      2'b01:   return b;
      2'b10:   return (a == b) ? 4'h1 : 4'h0;
      default: return (a < b) ? 4'h1 : 4'h0;
    endcase
  endfunction

  // reference model: 0 idle, 1 exec, 2 resp
  int         m_st = 0;
  logic       m_ptr = 1'b0;
  int         m_cnt0 = 0, m_cnt1 = 0, m_sat0 = 0, m_sat1 = 0;
  logic [4:0] sb_q[$];
  logic [1:0] exp_rdy;
  logic       g_id;

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) begin
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data",  32'(rsp_data),  32'd0);
        chk("rst_rsp_id",    32'(rsp_id),    32'd0);
        chk("rst_gnt_cnt0",  32'(gnt_cnt0),  32'd0);
        chk("rst_gnt_cnt1",  32'(gnt_cnt1),  32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        m_st = 0; m_ptr = 1'b0; m_cnt0 = 0; m_cnt1 = 0; m_sat0 = 0; m_sat1 = 0;
        sb_q.delete();
      end else begin
        exp_rdy = 2'b00;
        if (m_st == 0) begin
          if (req_valid[m_ptr]) exp_rdy[m_ptr] = 1'b1;
          else if (req_valid[!m_ptr]) exp_rdy[!m_ptr] = 1'b1;
        end
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("busy", 32'(busy), (m_st != 0) ? 32'd1 : 32'd0);
        chk("rsp_valid", 32'(rsp_valid), (m_st == 2) ? 32'd1 : 32'd0);
        chk("gnt_cnt0", 32'(gnt_cnt0), 32'(m_cnt0));
        chk("gnt_cnt1", 32'(gnt_cnt1), 32'(m_cnt1));
        chk("sat_gnt_cnt0", 32'(s_gnt_cnt0), 32'(m_sat0));
        chk("sat_gnt_cnt1", 32'(s_gnt_cnt1), 32'(m_sat1));
        if (m_st == 2) begin
          if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
          end else begin
            chk("rsp_data", 32'(rsp_data), 32'(sb_q[0][3:0]));
            chk("rsp_id",   32'(rsp_id),   32'(sb_q[0][4]));
          end
          if (rsp_ready) begin
            if (sb_q.size() != 0) void'(sb_q.pop_front());
            m_st = 0;
          end
        end else if (m_st == 1) begin
          m_st = 2;
        end else if (exp_rdy != 2'b00) begin
          g_id = exp_rdy[1];
          if (g_id) sb_q.push_back({1'b1, exp_res(req1_a, req1_b, req1_op)});
          else      sb_q.push_back({1'b0, exp_res(req0_a, req0_b, req0_op)});
          m_ptr = !g_id;
          if (g_id) begin
            if (m_cnt1 < 255) m_cnt1++;
            if (m_sat1 < 3) m_sat1++;
          end else begin
            if (m_cnt0 < 255) m_cnt0++;
            if (m_sat0 < 3) m_sat0++;
          end
          m_st = 1;
        end
      end
    end
  end

  task automatic wait_grant(input int id);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready[id]) begin ok = 1'b1; break; end
    end
    if (!ok) chk("grant_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic send(input int id, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    if (id == 0) begin req0_a = a; req0_b = b; req0_op = op; end
    else         begin req1_a = a; req1_b = b; req1_op = op; end
    req_valid[id] = 1'b1;
    wait_grant(id);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #2 rst = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // single EQ from requester 0
    send(0, 4'h5, 4'h5, 2'b10);
    wait_idle();

    // unsigned SLT from requester 1, both orders
    send(1, 4'h3, 4'hC, 2'b11);
    wait_idle();
    send(1, 4'hC, 4'h3, 2'b11);
    wait_idle();
    send(1, 4'h9, 4'h9, 2'b11);
    wait_idle();

    // both requesters continuously valid: six alternating grants
    req0_a = 4'h1; req0_b = 4'h2; req0_op = 2'b00;
    req1_a = 4'h7; req1_b = 4'h9; req1_op = 2'b01;
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    repeat (18) @(posedge clk);
    #1 req_valid = 2'b00;
    wait_idle();

    // back-pressure with operand change after grant and requester 1 pending
    rsp_ready = 1'b0;
    send(0, 4'hA, 4'h3, 2'b00);
    req0_a = 4'h2;
    req1_a = 4'h4; req1_b = 4'h4; req1_op = 2'b10;
    req_valid[1] = 1'b1;
    repeat (7) @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_grant(1);
    wait_idle();

    // reset asserted while holding a response
    rsp_ready = 1'b0;
    send(0, 4'h4, 4'h4, 2'b10);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    rsp_ready = 1'b1;

    // saturation of the narrow-counter instance
    for (int k = 0; k < 5; k++) begin
      send(0, 4'(k), 4'hF, 2'b00);
      wait_idle();
    end
    @(negedge clk);
    chk("sat_final_cnt0", 32'(s_gnt_cnt0), 32'd3);
    chk("wide_final_cnt0", 32'(gnt_cnt0), 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
